// File: rtl/mask_dec32.sv
// mask_dec32 -- builds a WIDTH-bit select/enable mask one bit at a time.
//
// A stream of bit-index commands arrives over a valid/ready handshake.
// Each index is decoded to a one-hot word and applied to the live mask
// register as SET, CLR or TOG. A COMMIT command publishes the mask and its
// population count through a registered valid/ready output, then reloads
// the live mask with INIT_MASK. No new command is accepted while a
// published mask is waiting to be taken.
//
// Optional build macro: MASK_DEC32_ERR_EN
//   When defined, adds a sticky 'err' output. It flags redundant commands
//   (SET of a bit already 1, CLR of a bit already 0) and is cleared when a
//   COMMIT is accepted.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   command valid
//   in_ready   out  command can be accepted (only while accumulating)
//   in_idx     in   [IDXW-1:0] bit index to decode
//   in_op      in   [1:0] 00 SET, 01 CLR, 10 TOG, 11 COMMIT (index ignored)
//   cur_mask   out  [WIDTH-1:0] live mask register
//   out_valid  out  published mask valid
//   out_ready  in   consumer takes the published mask
//   out_mask   out  [WIDTH-1:0] published mask
//   out_count  out  [IDXW:0] population count of out_mask
//   err        out  sticky redundant-command flag (MASK_DEC32_ERR_EN only)

module mask_dec32 #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] INIT_MASK = '0,
  parameter int               IDXW      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDXW-1:0]  in_idx,
  input  logic [1:0]       in_op,
  output logic [WIDTH-1:0] cur_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mask,
  output logic [IDXW:0]    out_count
`ifdef MASK_DEC32_ERR_EN
  ,
  output logic             err
`endif
);

  localparam logic [1:0] OP_SET    = 2'b00;
  localparam logic [1:0] OP_CLR    = 2'b01;
  localparam logic [1:0] OP_TOG    = 2'b10;
  localparam logic [1:0] OP_COMMIT = 2'b11;

  typedef enum logic {
    ACC,
    OUT
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] one_hot;
  logic [WIDTH-1:0] next_mask;
  logic             take_in;
  logic             take_out;
  logic             do_commit;

  // Count is IDXW+1 bits so an all-ones mask (WIDTH) fits without overflow.
  function automatic logic [IDXW:0] popcount(input logic [WIDTH-1:0] v);
    logic [IDXW:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + {{IDXW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Ready depends only on state, so there is no path from out_ready.
  assign in_ready  = (state == ACC);
  assign take_in   = in_valid && in_ready;
  assign take_out  = out_valid && out_ready;
  assign do_commit = take_in && (in_op == OP_COMMIT);

  // One-hot decode; a shift of a single 1 cannot wrap for any legal index.
  assign one_hot = {{(WIDTH-1){1'b0}}, 1'b1} << in_idx;

  // Next-state and next-mask logic
  always_comb begin
    next_state = state;
    next_mask  = cur_mask;
    case (state)
      ACC: begin
        if (take_in) begin
          case (in_op)
            OP_SET:    next_mask = cur_mask | one_hot;
            OP_CLR:    next_mask = cur_mask & ~one_hot;
            OP_TOG:    next_mask = cur_mask ^ one_hot;
            OP_COMMIT: begin
              next_mask  = INIT_MASK;
              next_state = OUT;
            end
            default:   next_mask = cur_mask;
          endcase
        end
      end
      OUT: begin
        if (take_out) begin
          next_state = ACC;
        end
      end
      default: next_state = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      state <= next_state;
    end
  end

  // Live mask plus the published output registers. out_mask/out_count only
  // load on a commit, so they hold steady while waiting and after transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_mask  <= INIT_MASK;
      out_valid <= 1'b0;
      out_mask  <= '0;
      out_count <= '0;
    end else begin
      cur_mask <= next_mask;
      if (do_commit) begin
        out_mask  <= cur_mask;
        out_count <= popcount(cur_mask);
        out_valid <= 1'b1;
      end else if (take_out) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MASK_DEC32_ERR_EN
  logic redundant;

  // A SET of a 1 bit or a CLR of a 0 bit leaves the mask unchanged.
  assign redundant = take_in &&
                     (((in_op == OP_SET) && (|(cur_mask & one_hot))) ||
                      ((in_op == OP_CLR) && !(|(cur_mask & one_hot))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (do_commit) begin
      err <= 1'b0;
    end else if (redundant) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mask_dec32.sv
// tb_mask_dec32 -- self-checking bench for mask_dec32.
// A bit-level model of the mask and published result is kept alongside the
// DUT and compared on every falling clock edge; directed scenarios add
// hand-computed literal expectations.

module tb_mask_dec32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_idx;
  logic [1:0]  in_op;
  logic [31:0] cur_mask;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_mask;
  logic [5:0]  out_count;
`ifdef MASK_DEC32_ERR_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] SET    = 2'b00;
  localparam logic [1:0] CLR    = 2'b01;
  localparam logic [1:0] TOG    = 2'b10;
  localparam logic [1:0] COMMIT = 2'b11;

  mask_dec32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_idx    (in_idx),
    .in_op     (in_op),
    .cur_mask  (cur_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mask  (out_mask),
    .out_count (out_count)
`ifdef MASK_DEC32_ERR_EN
    ,
    .err       (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a mask of bits, a busy flag for a waiting result.
  logic [31:0] m_cur;
  logic [31:0] m_out_mask;
  int          m_out_count;
  logic        m_busy;
  logic        m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cur       <= 32'h0;
      m_out_mask  <= 32'h0;
      m_out_count <= 0;
      m_busy      <= 1'b0;
      m_err       <= 1'b0;
    end else if (m_busy) begin
      if (out_ready) m_busy <= 1'b0;
    end else if (in_valid) begin
      case (in_op)
        SET: begin
          if (m_cur[in_idx]) m_err <= 1'b1;
          m_cur[in_idx] <= 1'b1;
        end
        CLR: begin
          if (!m_cur[in_idx]) m_err <= 1'b1;
          m_cur[in_idx] <= 1'b0;
        end
        TOG: m_cur[in_idx] <= ~m_cur[in_idx];
        default: begin
          m_out_mask  <= m_cur;
          m_out_count <= $countones(m_cur);
          m_busy      <= 1'b1;
          m_cur       <= 32'h0;
          m_err       <= 1'b0;
        end
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    checkOutput("cur_mask", cur_mask, m_cur);
    checkOutput("in_ready", {31'b0, in_ready}, {31'b0, !m_busy});
    checkOutput("out_valid", {31'b0, out_valid}, {31'b0, m_busy});
    checkOutput("out_mask", out_mask, m_out_mask);
    checkOutput("out_count", {26'b0, out_count}, 32'(m_out_count));
`ifdef MASK_DEC32_ERR_EN
    checkOutput("err", {31'b0, err}, {31'b0, m_err});
`endif
  end

  // Drive one command and hold it until accepted; returns 2 time units
  // after the accepting edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [4:0] idx);
    logic rdy;
    bit   done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_idx   = idx;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #2;
      if (rdy) begin
        done = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout actual=0 expected=1");
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_idx    = 5'd0;
    in_op     = SET;
    out_ready = 1'b1;
    repeat (3) stepCycle();
    rst_n = 1'b1;
    stepCycle();

    // Idle after reset
    checkOutput("rst_cur_mask", cur_mask, 32'h0);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'h1);

    // SET 0, 31, 7 then COMMIT with consumer ready
    $display("[TB] scenario: set 0/31/7 commit");
    applyStimulus(SET, 5'd0);
    applyStimulus(SET, 5'd31);
    applyStimulus(SET, 5'd7);
    applyStimulus(COMMIT, 5'd0);
    checkOutput("t2_out_valid", {31'b0, out_valid}, 32'h1);
    checkOutput("t2_out_mask", out_mask, 32'h8000_0081);
    checkOutput("t2_out_count", {26'b0, out_count}, 32'd3);
    checkOutput("t2_cur_mask", cur_mask, 32'h0);
    stepCycle();
    checkOutput("t2_valid_one_cycle", {31'b0, out_valid}, 32'h0);
    checkOutput("t2_in_ready", {31'b0, in_ready}, 32'h1);

    // SET 4, TOG 4, TOG 9, CLR 2, COMMIT
    $display("[TB] scenario: set/tog/clr mix");
    applyStimulus(SET, 5'd4);
    applyStimulus(TOG, 5'd4);
    applyStimulus(TOG, 5'd9);
    applyStimulus(CLR, 5'd2);
    checkOutput("t3_cur_mask", cur_mask, 32'h0000_0200);
    applyStimulus(COMMIT, 5'd0);
    checkOutput("t3_out_mask", out_mask, 32'h0000_0200);
    checkOutput("t3_out_count", {26'b0, out_count}, 32'd1);
    stepCycle();

    // All ones, consumer stalls for 5 cycles
    $display("[TB] scenario: all ones with stall");
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) applyStimulus(SET, 5'(i));
    checkOutput("t4_cur_mask", cur_mask, 32'hFFFF_FFFF);
    applyStimulus(COMMIT, 5'd0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t4_out_mask", out_mask, 32'hFFFF_FFFF);
      checkOutput("t4_out_count", {26'b0, out_count}, 32'd32);
      checkOutput("t4_in_ready", {31'b0, in_ready}, 32'h0);
      checkOutput("t4_out_valid", {31'b0, out_valid}, 32'h1);
      stepCycle();
    end
    out_ready = 1'b1;
    stepCycle();
    checkOutput("t4_in_ready_after", {31'b0, in_ready}, 32'h1);
    checkOutput("t4_out_valid_after", {31'b0, out_valid}, 32'h0);
    checkOutput("t4_out_mask_hold", out_mask, 32'hFFFF_FFFF);

    // Empty commit, SET 3 held during OUT
    $display("[TB] scenario: empty commit with held command");
    out_ready = 1'b0;
    applyStimulus(COMMIT, 5'd0);
    in_valid = 1'b1;
    in_op    = SET;
    in_idx   = 5'd3;
    for (int i = 0; i < 3; i++) begin
      checkOutput("t5_out_mask", out_mask, 32'h0);
      checkOutput("t5_out_count", {26'b0, out_count}, 32'd0);
      checkOutput("t5_in_ready", {31'b0, in_ready}, 32'h0);
      checkOutput("t5_cur_mask", cur_mask, 32'h0);
      stepCycle();
    end
    out_ready = 1'b1;
    stepCycle();
    checkOutput("t5_cur_mask_acc", cur_mask, 32'h0);
    checkOutput("t5_in_ready_acc", {31'b0, in_ready}, 32'h1);
    stepCycle();
    in_valid = 1'b0;
    checkOutput("t5_cur_mask_set3", cur_mask, 32'h0000_0008);

    // Index 31 boundary via toggle
    $display("[TB] scenario: toggle bit 31");
    applyStimulus(CLR, 5'd3);
    applyStimulus(TOG, 5'd31);
    applyStimulus(COMMIT, 5'd0);
    checkOutput("t6_out_mask", out_mask, 32'h8000_0000);
    checkOutput("t6_out_count", {26'b0, out_count}, 32'd1);
    stepCycle();

    // Reset asserted mid-OUT drops the pending output at once
    $display("[TB] scenario: reset during output wait");
    out_ready = 1'b0;
    applyStimulus(SET, 5'd12);
    applyStimulus(COMMIT, 5'd0);
    checkOutput("t7_out_valid_pre", {31'b0, out_valid}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t7_out_valid_async", {31'b0, out_valid}, 32'h0);
    checkOutput("t7_in_ready_async", {31'b0, in_ready}, 32'h1);
    checkOutput("t7_out_mask_async", out_mask, 32'h0);
    @(posedge clk);
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    stepCycle();

`ifdef MASK_DEC32_ERR_EN
    $display("[TB] scenario: redundant set flag");
    applyStimulus(SET, 5'd5);
    checkOutput("t8_err_first", {31'b0, err}, 32'h0);
    applyStimulus(SET, 5'd5);
    checkOutput("t8_err_second", {31'b0, err}, 32'h1);
    applyStimulus(COMMIT, 5'd0);
    checkOutput("t8_err_cleared", {31'b0, err}, 32'h0);
    checkOutput("t8_out_mask", out_mask, 32'h0000_0020);
    stepCycle();
`endif

    repeat (2) stepCycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
